// File: rtl/tdc_ctrl_pkg.sv
// Shared definitions for the TDC channel controller: FSM state encoding,
// ASCII command bytes and a small constant helper for counter sizing.
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARG     = 3'd1,
    ST_EN_LOW  = 3'd2,
    ST_EN_WAIT = 3'd3,
    ST_SRST    = 3'd4
  } state_t;

  localparam logic [7:0] CMD_DEFINE = 8'h64;  // "d"
  localparam logic [7:0] CMD_STOP   = 8'h73;  // "s"
  localparam logic [7:0] CMD_PLAY   = 8'h70;  // "p"
  localparam logic [7:0] CMD_RESET  = 8'h72;  // "r"
  localparam logic [7:0] CMD_MASK   = 8'h6D;  // "m"

  // Largest of three cycle counts; sizes the shared sequence timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_seq_timer.sv
// Loadable down-counter shared by all timed sequence states. A load takes
// priority; otherwise it counts down and parks at zero (terminal count).
module tdc_seq_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count register: load on state entry, then decrement until zero, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/tdc_ctrl_seq.sv
// UART-command-driven power-up / soft-reset sequencer for N_CH TDC channels.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a command; "d"/"r"/"m" accepted here only
//   ST_ARG     | next strobed byte is the new channel mask
//   ST_EN_LOW  | masked enables held low for EN_LOW_CYCLES
//   ST_EN_WAIT | masked enables high, TDC boot wait for BOOT_CYCLES
//   ST_SRST    | masked soft_reset high for RESET_PULSE cycles
module tdc_ctrl_seq
  import tdc_ctrl_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int EN_LOW_CYCLES = 16,
  parameter int BOOT_CYCLES   = 1048576,
  parameter int RESET_PULSE   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            new_rx_data,
  output logic [N_CH-1:0] tdc_enable,
  output logic [N_CH-1:0] soft_reset,
  output logic            pause,
  output logic            busy,
  output logic [N_CH-1:0] ch_mask,
  output logic            cmd_err
);

  localparam int MAX_CYC = max3(EN_LOW_CYCLES, BOOT_CYCLES, RESET_PULSE);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Each timed state runs for N cycles, so the timer is loaded with N-1.
  localparam logic [CNT_W-1:0] LD_EN_LOW = CNT_W'(EN_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_BOOT   = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SRST   = CNT_W'(RESET_PULSE - 1);

  state_t            state, state_nxt;
  logic [N_CH-1:0]   act_mask, act_mask_nxt;
  logic [N_CH-1:0]   en_nxt, srst_nxt, ch_mask_nxt;
  logic              pause_nxt, busy_nxt, err_nxt;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_val;

  tdc_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, timer control and next output values. Sequence progression
  // runs independently of commands; commands only move the FSM in IDLE/ARG.
  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    act_mask_nxt = act_mask;
    ch_mask_nxt  = ch_mask;
    pause_nxt    = pause;
    err_nxt      = 1'b0;
    en_nxt       = tdc_enable;

    unique case (state)
      ST_EN_LOW: begin
        if (tmr_done) begin
          state_nxt = ST_EN_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = LD_BOOT;
          en_nxt    = tdc_enable | act_mask;
        end
      end
      ST_EN_WAIT: begin
        if (tmr_done) begin
          state_nxt = ST_SRST;
          tmr_load  = 1'b1;
          tmr_val   = LD_SRST;
        end
      end
      ST_SRST: begin
        if (tmr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (new_rx_data) begin
      if (state == ST_ARG) begin
        // Any byte here is the mask argument, including "s"/"p".
        ch_mask_nxt = rx_data[N_CH-1:0];
        state_nxt   = ST_IDLE;
      end else if (rx_data == CMD_STOP) begin
        pause_nxt = 1'b1;
      end else if (rx_data == CMD_PLAY) begin
        pause_nxt = 1'b0;
      end else if (state == ST_IDLE && rx_data == CMD_DEFINE && ch_mask != '0) begin
        state_nxt    = ST_EN_LOW;
        tmr_load     = 1'b1;
        tmr_val      = LD_EN_LOW;
        act_mask_nxt = ch_mask;
        en_nxt       = tdc_enable & ~ch_mask;
      end else if (state == ST_IDLE && rx_data == CMD_RESET && ch_mask != '0) begin
        state_nxt    = ST_SRST;
        tmr_load     = 1'b1;
        tmr_val      = LD_SRST;
        act_mask_nxt = ch_mask;
      end else if (state == ST_IDLE && rx_data == CMD_MASK) begin
        state_nxt = ST_ARG;
      end else begin
        err_nxt = 1'b1;
      end
    end

    busy_nxt = (state_nxt == ST_EN_LOW) || (state_nxt == ST_EN_WAIT) ||
               (state_nxt == ST_SRST);
    srst_nxt = (state_nxt == ST_SRST) ? act_mask_nxt : '0;
  end

  // Registered outputs and latched active mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdc_enable <= '0;
      soft_reset <= '0;
      pause      <= 1'b0;
      busy       <= 1'b0;
      ch_mask    <= '1;
      cmd_err    <= 1'b0;
      act_mask   <= '0;
    end else begin
      tdc_enable <= en_nxt;
      soft_reset <= srst_nxt;
      pause      <= pause_nxt;
      busy       <= busy_nxt;
      ch_mask    <= ch_mask_nxt;
      cmd_err    <= err_nxt;
      act_mask   <= act_mask_nxt;
    end
  end

endmodule

// File: tb/tb_tdc_ctrl_seq.sv
// Directed bench for tdc_ctrl_seq with N_CH=2, EN_LOW=3, BOOT=10, RESET_PULSE=2.
module tb_tdc_ctrl_seq;

  localparam logic [7:0] B_D = 8'h64;
  localparam logic [7:0] B_S = 8'h73;
  localparam logic [7:0] B_P = 8'h70;
  localparam logic [7:0] B_R = 8'h72;
  localparam logic [7:0] B_M = 8'h6D;
  localparam logic [7:0] B_X = 8'h78;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic [1:0] tdc_enable, soft_reset, ch_mask;
  logic       pause, busy, cmd_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] obs, exp_v;

  tdc_ctrl_seq #(
    .N_CH(2), .EN_LOW_CYCLES(3), .BOOT_CYCLES(10), .RESET_PULSE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tdc_enable(tdc_enable), .soft_reset(soft_reset), .pause(pause),
    .busy(busy), .ch_mask(ch_mask), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  assign obs = {tdc_enable, soft_reset, busy, pause, cmd_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte; returns at the observation point of the following cycle.
  task automatic send(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({obs, ch_mask} !== 9'b0000000_11) begin
      n_err++;
      $display("FAIL reset_async got=%b exp=%b", {obs, ch_mask}, 9'b0000000_11);
    end
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({obs, ch_mask} !== 9'b0000000_11) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, {obs, ch_mask}, 9'b0000000_11);
      end
    end
  endtask

  // Full sequence on both channels, starting from any enable value with mask=11.
  task automatic test_define();
    send(B_D);
    for (int k = 1; k <= 17; k++) begin
      exp_v = {((k <= 3) ? 2'b00 : 2'b11), ((k == 14 || k == 15) ? 2'b11 : 2'b00),
               (k <= 15), 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL define k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_mask();
    send(B_M);
    n_cmp++;
    if ({busy, ch_mask} !== 3'b0_11) begin
      n_err++;
      $display("FAIL mask_arg got=%b exp=%b", {busy, ch_mask}, 3'b0_11);
    end
    send(8'h01);
    n_cmp++;
    if ({cmd_err, ch_mask} !== 3'b0_01) begin
      n_err++;
      $display("FAIL mask_load got=%b exp=%b", {cmd_err, ch_mask}, 3'b0_01);
    end
    send(B_D);
    for (int k = 1; k <= 17; k++) begin
      exp_v = {((k <= 3) ? 2'b10 : 2'b11), ((k == 14 || k == 15) ? 2'b01 : 2'b00),
               (k <= 15), 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL mask_seq k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      tick();
    end
    send(B_M);
    send(8'h03);
    n_cmp++;
    if (ch_mask !== 2'b11) begin
      n_err++;
      $display("FAIL mask_restore got=%b exp=%b", ch_mask, 2'b11);
    end
  endtask

  task automatic test_pause();
    send(B_D);
    for (int k = 1; k <= 17; k++) begin
      exp_v = {((k <= 3) ? 2'b00 : 2'b11), ((k == 14 || k == 15) ? 2'b11 : 2'b00),
               (k <= 15), (k >= 6 && k <= 8), 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pause k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      if (k == 5) begin rx_data = B_S; new_rx_data = 1'b1; end
      if (k == 8) begin rx_data = B_P; new_rx_data = 1'b1; end
      tick();
      new_rx_data = 1'b0;
    end
  endtask

  task automatic test_err();
    send(B_D);
    for (int k = 1; k <= 18; k++) begin
      exp_v = {((k <= 3) ? 2'b00 : 2'b11), ((k == 14 || k == 15) ? 2'b11 : 2'b00),
               (k <= 15), 1'b0, (k == 5 || k == 17)};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL cmd_err k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      if (k == 4)  begin rx_data = B_D; new_rx_data = 1'b1; end
      if (k == 16) begin rx_data = B_X; new_rx_data = 1'b1; end
      tick();
      new_rx_data = 1'b0;
    end
  endtask

  task automatic test_zero_mask();
    send(B_M);
    send(8'h00);
    n_cmp++;
    if (ch_mask !== 2'b00) begin
      n_err++;
      $display("FAIL zero_mask got=%b exp=%b", ch_mask, 2'b00);
    end
    send(B_R);
    n_cmp++;
    if (obs !== 7'b11_00_0_0_1) begin
      n_err++;
      $display("FAIL zero_r got=%b exp=%b", obs, 7'b11_00_0_0_1);
    end
    tick();
    n_cmp++;
    if (obs !== 7'b11_00_0_0_0) begin
      n_err++;
      $display("FAIL zero_r_after got=%b exp=%b", obs, 7'b11_00_0_0_0);
    end
    send(B_D);
    n_cmp++;
    if (obs !== 7'b11_00_0_0_1) begin
      n_err++;
      $display("FAIL zero_d got=%b exp=%b", obs, 7'b11_00_0_0_1);
    end
    // "s" inside ARG is a mask byte (bits 11), not a pause command.
    send(B_M);
    send(B_S);
    n_cmp++;
    if ({pause, ch_mask} !== 3'b0_11) begin
      n_err++;
      $display("FAIL arg_s got=%b exp=%b", {pause, ch_mask}, 3'b0_11);
    end
    send(B_R);
    for (int k = 1; k <= 3; k++) begin
      exp_v = {2'b11, ((k <= 2) ? 2'b11 : 2'b00), (k <= 2), 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL srst_cmd k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    send(B_M);
    send(8'h02);
    send(B_S);
    send(B_D);
    for (int k = 1; k <= 5; k++) begin
      exp_v = {((k <= 3) ? 2'b01 : 2'b11), 2'b00, 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL mid_pre k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      tick();
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({obs, ch_mask} !== 9'b0000000_11) begin
      n_err++;
      $display("FAIL mid_reset got=%b exp=%b", {obs, ch_mask}, 9'b0000000_11);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (obs !== 7'b0) begin
        n_err++;
        $display("FAIL mid_idle k=%0d got=%b exp=%b", k, obs, 7'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_define();
    test_mask();
    test_pause();
    test_err();
    test_zero_mask();
    test_reset_mid();
    test_define();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_ctrl_seq.md
Name: tdc_ctrl_seq

Overview:
UART-command-driven controller for N TDC channels. It decodes single-byte ASCII commands from the UART receiver and generates, per channel:
- the TDC enable power-up sequence: timed enable-low, boot wait, then soft-reset pulse;
- a global measurement pause flag.
It generalises the single-channel controller with a channel mask, parametrised timing, registered outputs, busy/error status and a standalone soft-reset command. It sits between the UART rx block and the TDC SPI/config blocks.

Parameters:
- N_CH, 2, number of TDC channels (1..8).
- EN_LOW_CYCLES, 16, cycles enable is held low before rising (>=1).
- BOOT_CYCLES, 1048576, cycles from enable rising to soft-reset assertion (>=1; ~21 ms at 50 MHz).
- RESET_PULSE, 4, soft_reset pulse width in cycles (>=1).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx_data, in, 8, received UART byte.
- new_rx_data, in, 1, one-cycle strobe; rx_data valid when high.
- tdc_enable, out, N_CH, per-channel TDC ENABLE pin drive.
- soft_reset, out, N_CH, per-channel soft-reset request to TDC config logic (level, RESET_PULSE cycles).
- pause, out, 1, measurement pause flag.
- busy, out, 1, high while a sequence is running.
- ch_mask, out, N_CH, current channel mask (status readback).
- cmd_err, out, 1, one-cycle pulse on a rejected or unknown command.

Behaviour:
- Reset values (async on rst_n low): tdc_enable=0, soft_reset=0, pause=0, busy=0, ch_mask=all ones, cmd_err=0, state=IDLE, counter=0. All outputs are registered.
- Commands, sampled only when new_rx_data=1:
  - "s": pause<=1. "p": pause<=0. Both are accepted in every state, including mid-sequence and ARG.
  - "d" (IDLE only): start power-up sequence on masked channels.
  - "r" (IDLE only): soft-reset pulse only, no enable cycling.
  - "m" (IDLE only): go to ARG; the next strobed byte's bits [N_CH-1:0] become ch_mask.
  - Any other byte, or "d"/"r"/"m" while not in IDLE: cmd_err pulses the following cycle; no state change.
  - "d" or "r" with ch_mask=0: cmd_err; stay in IDLE.
- States: IDLE, ARG, EN_LOW, EN_WAIT, SRST.
  - IDLE -"d"-> EN_LOW. IDLE -"r"-> SRST. IDLE -"m"-> ARG.
  - ARG: the next strobe loads ch_mask and returns to IDLE. A byte of "s"/"p" in ARG is consumed as the mask argument, not as a pause command. There is no timeout.
  - EN_LOW: masked tdc_enable bits = 0 for exactly EN_LOW_CYCLES cycles, then -> EN_WAIT.
  - EN_WAIT: masked tdc_enable bits = 1 for exactly BOOT_CYCLES cycles, then -> SRST.
  - SRST: masked soft_reset bits = 1 for exactly RESET_PULSE cycles, then -> IDLE.
- Timing: if "d" is strobed in cycle T, tdc_enable masked bits fall and busy rises at T+1. Enable rises at T+1+EN_LOW_CYCLES. soft_reset rises at T+1+EN_LOW_CYCLES+BOOT_CYCLES. busy falls together with soft_reset.
- busy=1 in EN_LOW, EN_WAIT and SRST; busy=0 in IDLE and ARG.
- Unmasked channels hold their tdc_enable value throughout. ch_mask is latched at sequence start into an internal active mask, so it is stable for the whole sequence.
- Counter: one shared down-counter, width $clog2(max(EN_LOW_CYCLES, BOOT_CYCLES, RESET_PULSE)+1). It is loaded with N-1 on entry to a timed state; the state exits when the count is 0 and the counter never wraps.
- rst_n asserted mid-sequence: all outputs return to reset values immediately, including tdc_enable=0 on every channel.
- After rst_n, tdc_enable stays 0 until "d" is received; the TDCs are never auto-enabled.

Decomposition:
- Shared package tdc_ctrl_pkg holds:
  - state encoding constants;
  - ASCII command constants CMD_DEFINE="d", CMD_STOP="s", CMD_PLAY="p", CMD_RESET="r", CMD_MASK="m".
- One sub-module, tdc_seq_timer: the loadable down-counter with a done flag, reused for all three timed states.

Test Plan (N_CH=2, EN_LOW_CYCLES=3, BOOT_CYCLES=10, RESET_PULSE=2):
- Reset, then strobe "d" at cycle T -> tdc_enable=00 and busy=1 over T+1..T+3; tdc_enable=11 from T+4; soft_reset=11 over T+14..T+15; busy=0 at T+16.
- "m", then 0x01, then "d" -> ch_mask=01; only tdc_enable[0] and soft_reset[0] sequence; bit 1 is held.
- "s" mid-EN_WAIT, then "p" -> pause=1 the cycle after "s" and 0 after "p"; the sequence completes with unchanged timing.
- "d" while busy, and the byte "x" in IDLE -> cmd_err one-cycle pulse each; timing of the running sequence unaffected.
- "m", then 0x00, then "r" -> cmd_err on "r"; no soft_reset; state stays IDLE.
- rst_n low during EN_WAIT -> tdc_enable=00, busy=0 and soft_reset=00 immediately; a subsequent "d" runs a full fresh sequence.
